game_over_detector: RTL and testbench
=====================================

Name: game_over_detector

Overview:
- Upstream producer of the 1-bit lose-game status sampled by the Avalon input PIO and read by the Nios II software.
- Tracks player lives from per-pixel collision hits, evaluated once per video frame.
- Applies an invulnerability window after each hit and asserts a sticky lose_game level when lives reach zero.
- Runs in the same clk domain as the PIO and the VGA controller. All inputs are synchronous to clk.

Parameters:
- INIT_LIVES, 3, lives loaded at reset and on restart; must satisfy 1 <= INIT_LIVES <= 2^LIVES_W-1.
- LIVES_W, 3, width of the lives counter and the lives output.
- INVULN_FRAMES, 60, frame boundaries of invulnerability after a non-fatal hit; 0 disables invulnerability.
- INVULN_W, 8, width of the invulnerability frame counter; must hold INVULN_FRAMES.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- frame_start  input  1  single-cycle pulse at the vertical-sync frame boundary.
- collision  input  1  level; high on any cycle in which player and hazard pixels overlap.
- restart  input  1  single-cycle pulse from the game-control PIO that starts a new game.
- lose_game  output  1  sticky game-over level; drives the lose-game PIO in_port.
- lives  output  LIVES_W  current lives remaining.
- invuln  output  1  high while in the INVULN state.
- hit_pulse  output  1  one-cycle pulse when a hit is charged.

Behaviour:
- Reset values (asynchronous):
  - state = PLAYING, lives = INIT_LIVES
  - lose_game = 0, invuln = 0, hit_pulse = 0
  - hit_pending = 0, inv_cnt = 0
- All outputs are registered. Each output updates on the clk edge where frame_start or restart is sampled and is visible the following cycle.
- hit_pending:
  - Set on any cycle with collision = 1.
  - Cleared on every frame_start and on every restart, in all states.
  - The effective hit at a frame_start is hit_pending OR collision in that same cycle.
- State PLAYING, on frame_start with an effective hit:
  - hit_pulse = 1 for one cycle.
  - If lives == 1: lives = 0, go to DEAD, lose_game = 1.
  - Else if INVULN_FRAMES == 0: lives = lives - 1, remain in PLAYING.
  - Else: lives = lives - 1, inv_cnt = INVULN_FRAMES, go to INVULN, invuln = 1.
- State PLAYING, on frame_start with no hit: no change.
- State INVULN, on frame_start:
  - Collisions are ignored; hit_pending is still cleared.
  - If inv_cnt == 1: inv_cnt = 0, go to PLAYING, invuln = 0.
  - Else: inv_cnt = inv_cnt - 1.
  - Invulnerability therefore spans exactly INVULN_FRAMES frame boundaries after the hit boundary.
- State DEAD:
  - lose_game held at 1 and lives held at 0.
  - frame_start and collision have no effect.
- restart, in any state:
  - Next cycle: state = PLAYING, lives = INIT_LIVES, lose_game = 0, invuln = 0, inv_cnt = 0, hit_pulse = 0, hit_pending = 0.
  - restart has priority over frame_start in the same cycle; no hit is charged in that cycle.
- A collision held across many cycles of one frame charges at most one hit per frame boundary.
- lives never underflows; no decrement occurs outside PLAYING.
- Reset asserted mid-game returns to the reset values immediately, with no dependence on the clock.

Test Plan:
(INIT_LIVES=3, INVULN_FRAMES=4 unless stated)
- Reset, then 10 frame_start pulses with collision = 0 -> lives = 3, lose_game = 0, invuln = 0, hit_pulse never asserted.
- collision high for 50 cycles within one frame, then frame_start -> one hit_pulse, lives = 2, invuln = 1. Collision held high for the next 4 frames -> lives stays 2, invuln drops to 0 the cycle after the 4th frame_start.
- Three hits, each separated by more than 4 frames -> lives goes 2, 1, 0. lose_game = 1 the cycle after the third hit boundary. Further frames with collision -> lives stays 0, lose_game stays 1.
- In DEAD, pulse restart and frame_start in the same cycle with collision = 1 -> next cycle lives = 3, lose_game = 0, no hit_pulse. The following frame_start without collision -> lives stays 3.
- INVULN_FRAMES=0: hits on 3 consecutive frame_starts -> lives 2, 1, 0, invuln always 0, lose_game = 1 after the third. collision pulsed only on the frame_start cycle itself -> still counted as a hit.
- Assert reset_n low mid-INVULN with lives = 1 -> outputs immediately lives = 3, invuln = 0, lose_game = 0, no clock edge required.

Source files
------------

// File: rtl/game_over_detector.sv
// game_over_detector
//   Tracks player lives from pixel collisions, charged once per video frame,
//   with an invulnerability window after each non-fatal hit. Raises a sticky
//   lose_game level when lives reach zero; restart starts a new game.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   frame_start  one-cycle pulse at the vertical-sync frame boundary
//   collision    level, high while player and hazard pixels overlap
//   restart      one-cycle pulse that starts a new game
//   lose_game    sticky game-over level (registered)
//   lives        lives remaining (registered)
//   invuln       high while invulnerable (registered)
//   hit_pulse    one-cycle pulse when a hit is charged (registered)
module game_over_detector #(
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned LIVES_W       = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned INVULN_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               collision,
  input  logic               restart,
  output logic               lose_game,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               hit_pulse
);

  localparam logic [LIVES_W-1:0]  LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0]  LIVES_ONE  = LIVES_W'(1);
  localparam logic [INVULN_W-1:0] INV_LOAD   = INVULN_W'(INVULN_FRAMES);
  localparam logic [INVULN_W-1:0] INV_ONE    = INVULN_W'(1);
  localparam bit                  INV_EN     = (INVULN_FRAMES != 0);

  typedef enum logic [1:0] {
    ST_PLAYING = 2'd0,
    ST_INVULN  = 2'd1,
    ST_DEAD    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [INVULN_W-1:0] inv_cnt_q, inv_cnt_d;
  logic                pend_q, pend_d;
  logic                lose_q, lose_d;
  logic                invuln_q, invuln_d;
  logic                hit_q, hit_d;
  logic                eff_hit;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PLAYING;
      lives_q   <= LIVES_INIT;
      inv_cnt_q <= '0;
      pend_q    <= 1'b0;
      lose_q    <= 1'b0;
      invuln_q  <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      inv_cnt_q <= inv_cnt_d;
      pend_q    <= pend_d;
      lose_q    <= lose_d;
      invuln_q  <= invuln_d;
      hit_q     <= hit_d;
    end
  end

  // A collision on the boundary cycle itself still counts for that frame
  assign eff_hit = pend_q | collision;

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    inv_cnt_d = inv_cnt_q;
    pend_d    = pend_q | collision;
    lose_d    = lose_q;
    invuln_d  = invuln_q;
    hit_d     = 1'b0;

    if (restart) begin
      // restart outranks frame_start: no hit is charged this cycle
      state_d   = ST_PLAYING;
      lives_d   = LIVES_INIT;
      inv_cnt_d = '0;
      pend_d    = 1'b0;
      lose_d    = 1'b0;
      invuln_d  = 1'b0;
    end else if (frame_start) begin
      pend_d = 1'b0;
      unique case (state_q)
        ST_PLAYING: begin
          if (eff_hit) begin
            hit_d = 1'b1;
            if (lives_q == LIVES_ONE) begin
              lives_d = '0;
              state_d = ST_DEAD;
              lose_d  = 1'b1;
            end else begin
              lives_d = lives_q - LIVES_ONE;
              if (INV_EN) begin
                inv_cnt_d = INV_LOAD;
                state_d   = ST_INVULN;
                invuln_d  = 1'b1;
              end
            end
          end
        end
        ST_INVULN: begin
          // Collisions ignored; count down remaining protected boundaries
          if (inv_cnt_q <= INV_ONE) begin
            inv_cnt_d = '0;
            state_d   = ST_PLAYING;
            invuln_d  = 1'b0;
          end else begin
            inv_cnt_d = inv_cnt_q - INV_ONE;
          end
        end
        ST_DEAD: begin
          lives_d = '0;
          lose_d  = 1'b1;
        end
        default: begin
          state_d  = ST_PLAYING;
          invuln_d = 1'b0;
        end
      endcase
    end
  end

  assign lose_game = lose_q;
  assign lives     = lives_q;
  assign invuln    = invuln_q;
  assign hit_pulse = hit_q;

endmodule

// File: tb/tb_game_over_detector.sv
module tb_game_over_detector;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: INVULN_FRAMES=4, instance B: INVULN_FRAMES=0
  logic       fs_a = 0, col_a = 0, rs_a = 0;
  logic       lose_a, inv_a, hit_a;
  logic [2:0] lives_a;
  logic       fs_b = 0, col_b = 0, rs_b = 0;
  logic       lose_b, inv_b, hit_b;
  logic [2:0] lives_b;

  game_over_detector #(.INIT_LIVES(3), .LIVES_W(3), .INVULN_FRAMES(4), .INVULN_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .frame_start(fs_a), .collision(col_a), .restart(rs_a),
    .lose_game(lose_a), .lives(lives_a), .invuln(inv_a), .hit_pulse(hit_a));

  game_over_detector #(.INIT_LIVES(3), .LIVES_W(3), .INVULN_FRAMES(0), .INVULN_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .frame_start(fs_b), .collision(col_b), .restart(rs_b),
    .lose_game(lose_b), .lives(lives_b), .invuln(inv_b), .hit_pulse(hit_b));

  typedef struct {
    bit       sel;      // 0 = dut_a, 1 = dut_b
    int       gap;      // idle cycles before the event cycle
    bit       col_gap;  // collision level during the gap
    bit       fs;
    bit       col;
    bit       rs;
    int       e_lives;
    bit       e_lose;
    bit       e_inv;
    bit       e_hit;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic add(input bit sel, input int gap, input bit col_gap, input bit fs,
                     input bit col, input bit rs, input int el, input bit elo,
                     input bit ei, input bit eh);
    vec_t v;
    v.sel = sel; v.gap = gap; v.col_gap = col_gap; v.fs = fs; v.col = col; v.rs = rs;
    v.e_lives = el; v.e_lose = elo; v.e_inv = ei; v.e_hit = eh;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit fs, input bit col, input bit rs);
    fs_a = sel ? 1'b0 : fs;  col_a = sel ? 1'b0 : col;  rs_a = sel ? 1'b0 : rs;
    fs_b = sel ? fs : 1'b0;  col_b = sel ? col : 1'b0;  rs_b = sel ? rs : 1'b0;
  endtask

  function automatic int get_lives(input bit sel);
    return sel ? int'(lives_b) : int'(lives_a);
  endfunction

  task automatic apply(input int idx, input vec_t v);
    for (int c = 0; c < v.gap; c++) begin
      @(negedge clk);
      drive(v.sel, 1'b0, v.col_gap, 1'b0);
      @(posedge clk); #1;
      if (c == 0)
        chk($sformatf("v%0d_gap_hit", idx), v.sel ? hit_b : hit_a, 0);
    end
    @(negedge clk);
    drive(v.sel, v.fs, v.col, v.rs);
    @(posedge clk); #1;
    chk($sformatf("v%0d_lives", idx), get_lives(v.sel), v.e_lives);
    chk($sformatf("v%0d_lose", idx), v.sel ? lose_b : lose_a, v.e_lose);
    chk($sformatf("v%0d_invuln", idx), v.sel ? inv_b : inv_a, v.e_inv);
    chk($sformatf("v%0d_hit", idx), v.sel ? hit_b : hit_a, v.e_hit);
    @(negedge clk);
    drive(v.sel, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // ---- dut_a, INVULN_FRAMES=4 ----
    for (int i = 0; i < 10; i++) add(0, 2, 0, 1, 0, 0, 3, 0, 0, 0);   // quiet frames
    add(0, 50, 1, 1, 0, 0, 2, 0, 1, 1);                                // long collision -> one hit
    for (int i = 0; i < 3; i++) add(0, 3, 1, 1, 1, 0, 2, 0, 1, 0);     // held collision ignored
    add(0, 3, 1, 1, 1, 0, 2, 0, 0, 0);                                 // 4th boundary ends invuln
    add(0, 3, 0, 1, 0, 0, 2, 0, 0, 0);                                 // pending was cleared
    add(0, 3, 1, 1, 0, 0, 1, 0, 1, 1);                                 // hit -> 1
    for (int i = 0; i < 3; i++) add(0, 2, 0, 1, 0, 0, 1, 0, 1, 0);
    add(0, 2, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 2, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 2, 0, 1, 1, 0, 0, 1, 0, 1);                                 // fatal hit
    add(0, 3, 1, 1, 1, 0, 0, 1, 0, 0);                                 // dead: no effect
    add(0, 3, 1, 1, 1, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 1, 3, 0, 0, 0);                                 // restart beats frame+hit
    add(0, 2, 0, 1, 0, 0, 3, 0, 0, 0);
    add(0, 2, 1, 1, 0, 0, 2, 0, 1, 1);                                 // hit then restart in invuln
    add(0, 2, 0, 0, 0, 1, 3, 0, 0, 0);
    add(0, 2, 0, 1, 0, 0, 3, 0, 0, 0);
    // ---- dut_b, INVULN_FRAMES=0: collision only on the boundary cycle ----
    add(1, 2, 0, 1, 1, 0, 2, 0, 0, 1);
    add(1, 0, 0, 1, 1, 0, 1, 0, 0, 1);
    add(1, 0, 0, 1, 1, 0, 0, 1, 0, 1);
    add(1, 2, 1, 1, 1, 0, 0, 1, 0, 0);
    // ---- dut_a: reach INVULN with one life for the async reset check ----
    add(0, 2, 1, 1, 0, 0, 2, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 2, 0, 1, 0, 0, 2, 0, 1, 0);
    add(0, 2, 0, 1, 0, 0, 2, 0, 0, 0);
    add(0, 2, 1, 1, 0, 0, 1, 0, 1, 1);

    drive(0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lives_a", int'(lives_a), 3);
    chk("rst_lose_a", lose_a, 0);
    chk("rst_inv_a", inv_a, 0);
    chk("rst_hit_a", hit_a, 0);
    chk("rst_lives_b", int'(lives_b), 3);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Mid-INVULN with one life: reset must act without a clock edge
    @(posedge clk); #2;
    chk("pre_async_lives", int'(lives_a), 1);
    reset_n = 1'b0;
    #1;
    chk("async_lives", int'(lives_a), 3);
    chk("async_inv", inv_a, 0);
    chk("async_lose", lose_a, 0);
    chk("async_hit", hit_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    // After reset the pending hit and counter are gone: quiet frame, then a hit
    apply(100, '{0, 2, 0, 1, 0, 0, 3, 0, 0, 0});
    apply(101, '{0, 2, 1, 1, 0, 0, 2, 0, 1, 1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
